// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fetch/data arbiter onto a single sram-like memory bus
//
// Shares one external sram-like bus between the fetch-stage instruction port
// and the mem-stage data port. One transaction is outstanding at a time. Data
// wins ties, but a starvation counter forces an instruction grant after
// STARVE_MAX consecutive data grants taken while a fetch was waiting.
//
// Parameters
//   ADDR_W      address width
//   DATA_W      data width
//   STARVE_MAX  data grants allowed while a fetch waits; 0 = pure data priority
//
// Ports
//   clk, rst                          clock (rising edge), async active-low reset
//   inst_req/inst_addr                fetch request (read, word size)
//   inst_addr_ok/data_ok/rdata        fetch handshake and read data
//   data_req/wr/size/addr/wdata       data request
//   data_addr_ok/data_ok/rdata        data handshake and read data
//   bus_req/wr/size/addr/wdata        registered bus request fields
//   bus_addr_ok/data_ok/rdata         bus responses

module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } stateT;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } ownerT;

  stateT            state;
  ownerT            owner;
  logic [CNT_W-1:0] starveCnt;

  logic             complete;
  logic             arbitrate;
  logic             instPend;
  logic             dataPend;
  logic             starveHit;
  logic             grantInst;
  logic             grantData;
  logic             rdataActive;
  logic [CNT_W-1:0] starveNext;

  // A response completes either in WAIT or when address and data are
  // accepted together in ADDR; both cases re-arbitrate on the same edge.
  assign complete  = ((state == WAIT) && bus_data_ok) ||
                     ((state == ADDR) && bus_addr_ok && bus_data_ok);
  assign arbitrate = (state == IDLE) || complete;

  // When address and data complete together in ADDR, the owner's req is the
  // one being accepted this cycle, so it must not count as a new request.
  assign instPend = inst_req && !((state == ADDR) && (owner == OWN_INST));
  assign dataPend = data_req && !((state == ADDR) && (owner == OWN_DATA));

  assign starveHit = (STARVE_MAX != 0) && (starveCnt == STARVE_LIM);
  assign grantInst = instPend && (!dataPend || starveHit);
  assign grantData = dataPend && !grantInst;

  assign starveNext = (starveCnt == STARVE_LIM) ? starveCnt : starveCnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_INST;
      starveCnt <= '0;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_size  <= 2'b00;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else if (arbitrate) begin
      if (grantInst) begin
        state     <= ADDR;
        owner     <= OWN_INST;
        starveCnt <= '0;
        bus_req   <= 1'b1;
        bus_wr    <= 1'b0;
        bus_size  <= 2'b10;
        bus_addr  <= inst_addr;
        bus_wdata <= '0;
      end else if (grantData) begin
        state     <= ADDR;
        owner     <= OWN_DATA;
        if (instPend) begin
          starveCnt <= starveNext;
        end
        bus_req   <= 1'b1;
        bus_wr    <= data_wr;
        bus_size  <= data_size;
        bus_addr  <= data_addr;
        bus_wdata <= data_wdata;
      end else begin
        state   <= IDLE;
        bus_req <= 1'b0;
      end
    end else if ((state == ADDR) && bus_addr_ok) begin
      state   <= WAIT;
      bus_req <= 1'b0;
    end
  end

  // Read data is only forwarded while a response can be valid; the
  // non-owner always sees zero.
  assign rdataActive = (state == WAIT) || complete;

  always_comb begin
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    if (owner == OWN_INST) begin
      inst_addr_ok = (state == ADDR) && bus_addr_ok;
      inst_data_ok = complete;
      if (rdataActive) begin
        inst_rdata = bus_rdata;
      end
    end else begin
      data_addr_ok = (state == ADDR) && bus_addr_ok;
      data_data_ok = complete;
      if (rdataActive) begin
        data_rdata = bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed vector bench for mem_bus_arbiter
//
// Runs a cycle-by-cycle vector table through the STARVE_MAX=4 instance and
// hand-written sequences for starvation (both instances), bus stall and reset.

module tb_mem_bus_arbiter;

  localparam logic [31:0] IA = 32'hBFC00000;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;

  logic        zInstAddrOk, zInstDataOk, zDataAddrOk, zDataDataOk;
  logic [31:0] zInstRdata, zDataRdata;
  logic        zBusReq, zBusWr;
  logic [1:0]  zBusSize;
  logic [31:0] zBusAddr, zBusWdata;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(0)) dutNoStarve (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(zInstAddrOk), .inst_data_ok(zInstDataOk), .inst_rdata(zInstRdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(zDataAddrOk), .data_data_ok(zDataDataOk), .data_rdata(zDataRdata),
    .bus_req(zBusReq), .bus_wr(zBusWr), .bus_size(zBusSize),
    .bus_addr(zBusAddr), .bus_wdata(zBusWdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        iReq;
    logic        dReq;
    logic        dWr;
    logic [1:0]  dSize;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [1:0]  bOk;     // {bus_addr_ok, bus_data_ok}
    logic [31:0] bRdata;
    logic        eReq;
    logic        eWr;
    logic [1:0]  eSize;
    logic [31:0] eAddr;
    logic [31:0] eWdata;
    logic [3:0]  eOk;     // {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
    logic [31:0] eIRdata;
    logic [31:0] eDRdata;
  } vecT;

  vecT vecs[$];

  function automatic vecT v(string name, logic iReq, logic dReq, logic dWr,
                            logic [1:0] dSize, logic [31:0] dAddr, logic [31:0] dWdata,
                            logic [1:0] bOk, logic [31:0] bRdata,
                            logic eReq, logic eWr, logic [1:0] eSize,
                            logic [31:0] eAddr, logic [31:0] eWdata,
                            logic [3:0] eOk, logic [31:0] eIRdata, logic [31:0] eDRdata);
    vecT r;
    r.name = name; r.iReq = iReq; r.dReq = dReq; r.dWr = dWr; r.dSize = dSize;
    r.dAddr = dAddr; r.dWdata = dWdata; r.bOk = bOk; r.bRdata = bRdata;
    r.eReq = eReq; r.eWr = eWr; r.eSize = eSize; r.eAddr = eAddr; r.eWdata = eWdata;
    r.eOk = eOk; r.eIRdata = eIRdata; r.eDRdata = eDRdata;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    inst_req    = 1'b0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_addr   = '0;
    data_wdata  = '0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, ".bus_req"},   32'(bus_req), 32'd0);
    check({tag, ".bus_wr"},    32'(bus_wr), 32'd0);
    check({tag, ".bus_size"},  32'(bus_size), 32'd0);
    check({tag, ".bus_addr"},  bus_addr, 32'd0);
    check({tag, ".bus_wdata"}, bus_wdata, 32'd0);
    check({tag, ".oks"}, 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
    check({tag, ".inst_rdata"}, inst_rdata, 32'd0);
    check({tag, ".data_rdata"}, data_rdata, 32'd0);
  endtask

  int g1[$];
  int g0[$];
  int expSeq[10];

  initial begin
    inst_addr = IA;
    clearInputs();
    rst = 1'b0;
    step();
    step();
    step();
    checkIdleOutputs("reset");
    rst = 1'b1;

    // name, iReq dReq dWr dSize dAddr dWdata bOk bRdata | eReq eWr eSize eAddr eWdata eOk eIR eDR
    vecs.push_back(v("t1_idle",   1,0,0,0,0,0, 2'b00,0,            0,0,0,0,0, 4'b0000,0,0));
    vecs.push_back(v("t1_addr",   1,0,0,0,0,0, 2'b00,0,            1,0,2,IA,0, 4'b0000,0,0));
    vecs.push_back(v("t1_stall",  1,0,0,0,0,0, 2'b00,0,            1,0,2,IA,0, 4'b0000,0,0));
    vecs.push_back(v("t1_aok",    1,0,0,0,0,0, 2'b10,0,            1,0,2,IA,0, 4'b1000,0,0));
    vecs.push_back(v("t1_wait",   0,0,0,0,0,0, 2'b00,0,            0,0,0,0,0, 4'b0000,0,0));
    vecs.push_back(v("t1_dok",    0,0,0,0,0,0, 2'b01,32'h24080001, 0,0,0,0,0, 4'b0010,32'h24080001,0));
    vecs.push_back(v("t1_idle2",  0,0,0,0,0,0, 2'b00,0,            0,0,0,0,0, 4'b0000,0,0));
    vecs.push_back(v("t2_idle",   1,1,1,2,32'h10,32'hDEADBEEF, 2'b00,0, 0,0,0,0,0, 4'b0000,0,0));
    vecs.push_back(v("t2_dgrant", 1,1,1,2,32'h10,32'hDEADBEEF, 2'b00,0, 1,1,2,32'h10,32'hDEADBEEF, 4'b0000,0,0));
    vecs.push_back(v("t2_daok",   1,1,1,2,32'h10,32'hDEADBEEF, 2'b10,0, 1,1,2,32'h10,32'hDEADBEEF, 4'b0100,0,0));
    vecs.push_back(v("t2_wait",   1,0,0,0,0,0, 2'b00,0,            0,0,0,0,0, 4'b0000,0,0));
    vecs.push_back(v("t2_ddok",   1,0,0,0,0,0, 2'b01,32'h12345678, 0,0,0,0,0, 4'b0001,0,32'h12345678));
    vecs.push_back(v("t2_igrant", 1,0,0,0,0,0, 2'b00,0,            1,0,2,IA,0, 4'b0000,0,0));
    vecs.push_back(v("t2_iaok",   1,0,0,0,0,0, 2'b10,0,            1,0,2,IA,0, 4'b1000,0,0));
    vecs.push_back(v("t2_iwait",  0,0,0,0,0,0, 2'b00,0,            0,0,0,0,0, 4'b0000,0,0));
    vecs.push_back(v("t2_idok",   0,0,0,0,0,0, 2'b01,32'hAAAA5555, 0,0,0,0,0, 4'b0010,32'hAAAA5555,0));
    vecs.push_back(v("t5_idle",   0,1,0,0,32'h3,0, 2'b00,0,        0,0,0,0,0, 4'b0000,0,0));
    vecs.push_back(v("t5_dgrant", 0,1,0,0,32'h3,0, 2'b00,0,        1,0,0,32'h3,0, 4'b0000,0,0));
    vecs.push_back(v("t5_both",   1,1,0,0,32'h3,0, 2'b11,32'hEE,   1,0,0,32'h3,0, 4'b0101,0,32'hEE));
    vecs.push_back(v("t5_igrant", 1,0,0,0,0,0, 2'b00,0,            1,0,2,IA,0, 4'b0000,0,0));
    vecs.push_back(v("t5_iaok",   1,0,0,0,0,0, 2'b10,0,            1,0,2,IA,0, 4'b1000,0,0));
    vecs.push_back(v("t5_iwait",  0,0,0,0,0,0, 2'b00,0,            0,0,0,0,0, 4'b0000,0,0));
    vecs.push_back(v("t5_idok",   0,0,0,0,0,0, 2'b01,32'h11,       0,0,0,0,0, 4'b0010,32'h11,0));
    vecs.push_back(v("stray_idle",0,0,0,0,0,0, 2'b01,32'h99,       0,0,0,0,0, 4'b0000,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      inst_req    = vecs[i].iReq;
      data_req    = vecs[i].dReq;
      data_wr     = vecs[i].dWr;
      data_size   = vecs[i].dSize;
      data_addr   = vecs[i].dAddr;
      data_wdata  = vecs[i].dWdata;
      bus_addr_ok = vecs[i].bOk[1];
      bus_data_ok = vecs[i].bOk[0];
      bus_rdata   = vecs[i].bRdata;
      #2;
      check({vecs[i].name, ".bus_req"}, 32'(bus_req), 32'(vecs[i].eReq));
      if (vecs[i].eReq) begin
        check({vecs[i].name, ".bus_wr"},    32'(bus_wr), 32'(vecs[i].eWr));
        check({vecs[i].name, ".bus_size"},  32'(bus_size), 32'(vecs[i].eSize));
        check({vecs[i].name, ".bus_addr"},  bus_addr, vecs[i].eAddr);
        check({vecs[i].name, ".bus_wdata"}, bus_wdata, vecs[i].eWdata);
      end
      check({vecs[i].name, ".oks"},
            32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'(vecs[i].eOk));
      check({vecs[i].name, ".inst_rdata"}, inst_rdata, vecs[i].eIRdata);
      check({vecs[i].name, ".data_rdata"}, data_rdata, vecs[i].eDRdata);
      step();
    end

    // Starvation: both requesters always asking; an ideal bus answers
    // address one cycle after bus_req and data the cycle after that.
    doReset();
    inst_req  = 1'b1;
    data_req  = 1'b1;
    data_size = 2'd2;
    data_addr = 32'h40;
    begin
      bit pend;
      pend = 1'b0;
      for (int c = 0; c < 200 && (g1.size() < 10 || g0.size() < 10); c++) begin
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        if (pend) begin
          bus_data_ok = 1'b1;
          bus_rdata   = 32'(c);
          pend        = 1'b0;
        end else if (bus_req) begin
          bus_addr_ok = 1'b1;
          pend        = 1'b1;
        end
        #2;
        if (inst_addr_ok) g1.push_back(1);
        if (data_addr_ok) g1.push_back(0);
        if (zInstAddrOk)  g0.push_back(1);
        if (zDataAddrOk)  g0.push_back(0);
        step();
      end
    end
    expSeq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    check("t3.grant_count", 32'(g1.size() >= 10), 32'd1);
    check("t3.zero_grant_count", 32'(g0.size() >= 10), 32'd1);
    for (int k = 0; k < 10 && k < g1.size(); k++)
      check($sformatf("t3.grant%0d", k), 32'(g1[k]), 32'(expSeq[k]));
    for (int k = 0; k < 10 && k < g0.size(); k++)
      check($sformatf("t3.zero_grant%0d", k), 32'(g0[k]), 32'd0);

    // Bus stall: request fields must hold while bus_addr_ok stays low.
    doReset();
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = 2'd1;
    data_addr  = 32'h80;
    data_wdata = 32'hCAFEF00D;
    step();
    for (int k = 0; k < 10; k++) begin
      #2;
      check($sformatf("t4.bus_req%0d", k), 32'(bus_req), 32'd1);
      check($sformatf("t4.bus_addr%0d", k), bus_addr, 32'h80);
      check($sformatf("t4.bus_size%0d", k), 32'(bus_size), 32'd1);
      check($sformatf("t4.bus_wr%0d", k), 32'(bus_wr), 32'd1);
      check($sformatf("t4.bus_wdata%0d", k), bus_wdata, 32'hCAFEF00D);
      check($sformatf("t4.addr_oks%0d", k), 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      step();
    end
    bus_addr_ok = 1'b1;
    #2;
    check("t4.data_addr_ok", 32'(data_addr_ok), 32'd1);
    step();
    data_req    = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    #2;
    check("t4.data_data_ok", 32'(data_data_ok), 32'd1);
    step();
    bus_data_ok = 1'b0;

    // Reset while in WAIT, then a stray response.
    data_req   = 1'b1;
    data_wr    = 1'b0;
    data_size  = 2'd2;
    data_addr  = 32'h100;
    data_wdata = 32'h0;
    step();
    bus_addr_ok = 1'b1;
    #2;
    check("t6.pre_addr_ok", 32'(data_addr_ok), 32'd1);
    step();
    data_req    = 1'b0;
    bus_addr_ok = 1'b0;
    #2;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h77;
    rst         = 1'b0;
    #1;
    checkIdleOutputs("t6.in_reset");
    step();
    rst = 1'b1;
    #2;
    check("t6.stray_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    check("t6.stray_bus_req", 32'(bus_req), 32'd0);
    step();
    bus_data_ok = 1'b0;
    data_req    = 1'b1;
    data_addr   = 32'h200;
    step();
    #2;
    check("t6.post_bus_req", 32'(bus_req), 32'd1);
    check("t6.post_bus_addr", bus_addr, 32'h200);
    bus_addr_ok = 1'b1;
    #1;
    check("t6.post_addr_ok", 32'(data_addr_ok), 32'd1);
    step();
    data_req    = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h5A5A1234;
    #2;
    check("t6.post_data_ok", 32'(data_data_ok), 32'd1);
    check("t6.post_rdata", data_rdata, 32'h5A5A1234);
    step();
    bus_data_ok = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
